// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the load-use / flag hazard scoreboard.
package hazard_pkg;

   // Default cycles from load issue until its data can be forwarded.
   localparam int LOAD_LAT_DEF = 2;

   // Branch flavours seen in decode.
   localparam logic BR_TYPE_B  = 1'b0;   // waits on condition flags
   localparam logic BR_TYPE_BR = 1'b1;   // reads rs, resolved in decode

   // Bits needed to hold a countdown running from lat down to 0.
   function automatic int cnt_width(input int lat);
      return $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage bundle: the instruction being decoded flows in, the stall
// decision flows back. Decode holds its instruction for every cycle that
// stall is high; the instruction is taken only in a cycle where dec_valid=1,
// stall=0 and memory is not freezing the pipeline.
interface hazard_scoreboard_if #(
   parameter int REG_W = 4
);
   logic             dec_valid;
   logic [REG_W-1:0] dec_rs;
   logic [REG_W-1:0] dec_rt;
   logic             dec_rs_used;
   logic             dec_rt_used;
   logic             dec_rt_store;
   logic [REG_W-1:0] dec_rd;
   logic             dec_wr_en;
   logic             dec_is_load;
   logic             dec_sets_flags;
   logic             dec_branch;
   logic             dec_branch_type;
   logic             stall;

   modport master (
      output dec_valid, dec_rs, dec_rt, dec_rs_used, dec_rt_used, dec_rt_store,
             dec_rd, dec_wr_en, dec_is_load, dec_sets_flags, dec_branch,
             dec_branch_type,
      input  stall
   );

   modport slave (
      input  dec_valid, dec_rs, dec_rt, dec_rs_used, dec_rt_used, dec_rt_store,
             dec_rd, dec_wr_en, dec_is_load, dec_sets_flags, dec_branch,
             dec_branch_type,
      output stall
   );
endinterface

// File: rtl/hazard_sb_entry.sv
// One register's pending-write countdown: reload on issue, otherwise count
// down to zero while the pipeline advances, hold while memory freezes it.
module hazard_sb_entry
   import hazard_pkg::*;
#(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic [CW-1:0] cnt
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next countdown value: a new writer overrides whatever was pending.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Countdown register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight register writes and
// pending flag updates, raises stall for load-use, store-data, flag and
// register-branch hazards, and counts stall cycles.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int REG_W    = 4,
   parameter int LOAD_LAT = LOAD_LAT_DEF,
   parameter int STAT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   hazard_scoreboard_if.slave dec,
   input  logic               mem_ready,
   input  logic               stat_clr,
   output logic [STAT_W-1:0]  stall_count
);

   localparam int            CW    = cnt_width(LOAD_LAT);
   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [CW-1:0] TWO   = CW'(2);
   localparam logic [CW-1:0] LAT_V = CW'(LOAD_LAT);

   // Register 0 never has an entry, so it always reads as "ready".
   logic [CW-1:0]     cnt [1:NUM_REGS-1];
   logic [CW-1:0]     rs_cnt;
   logic [CW-1:0]     rt_cnt;
   logic [CW-1:0]     wr_val;
   logic              stall_c;
   logic              issue;
   logic              flag_pend_q;
   logic              flag_pend_d;
   logic [STAT_W-1:0] stall_count_q;
   logic [STAT_W-1:0] stall_count_d;

   // Look up the countdowns of both sources; index 0 or out-of-range reads 0.
   always_comb begin
      rs_cnt = '0;
      rt_cnt = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (dec.dec_rs == REG_W'(r)) rs_cnt = cnt[r];
         if (dec.dec_rt == REG_W'(r)) rt_cnt = cnt[r];
      end
   end

   // Stall decision from current (pre-issue) state; store data may arrive
   // one stage later, register branches need the value already in decode.
   always_comb begin
      stall_c = 1'b0;
      if (dec.dec_valid) begin
         stall_c = (dec.dec_rs_used && (rs_cnt > ONE))
                || (dec.dec_rt_used && !dec.dec_rt_store && (rt_cnt > ONE))
                || (dec.dec_rt_used &&  dec.dec_rt_store && (rt_cnt > TWO))
                || (dec.dec_branch && (dec.dec_branch_type == BR_TYPE_B) && flag_pend_q)
                || (dec.dec_branch && (dec.dec_branch_type == BR_TYPE_BR) && (rs_cnt != '0));
      end
   end

   assign dec.stall = stall_c;
   assign issue     = dec.dec_valid && !stall_c && mem_ready;
   assign wr_val    = dec.dec_is_load ? LAT_V : ONE;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
      hazard_sb_entry #(.CW(CW)) u_entry (
         .clk      (clk),
         .rst      (rst),
         .en       (mem_ready),
         .load     (issue && dec.dec_wr_en && (dec.dec_rd == REG_W'(r))),
         .load_val (wr_val),
         .cnt      (cnt[r])
      );
   end

   // Flags pending for exactly the cycle after a flag-setting issue.
   always_comb begin
      flag_pend_d = flag_pend_q;
      if (mem_ready) begin
         flag_pend_d = issue && dec.dec_sets_flags;
      end
   end

   // Saturating stall statistics; clear wins over counting.
   always_comb begin
      stall_count_d = stall_count_q;
      if (stat_clr) begin
         stall_count_d = '0;
      end else if (stall_c && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + STAT_W'(1);
      end
   end

   // Flag and statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         flag_pend_q   <= 1'b0;
         stall_count_q <= '0;
      end else begin
         flag_pend_q   <= flag_pend_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a LOAD_LAT=2 instance (main) and a
// LOAD_LAT=3, STAT_W=3 instance (alt) see identical decode stimulus.
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   typedef struct packed {
      logic       valid;
      logic [3:0] rs;
      logic [3:0] rt;
      logic       rs_used;
      logic       rt_used;
      logic       rt_store;
      logic [3:0] rd;
      logic       wr_en;
      logic       is_load;
      logic       sets_flags;
      logic       branch;
      logic       btype;
   } dec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_ready = 1'b1;
   logic        stat_clr = 1'b0;
   logic [15:0] cnt_m;
   logic [2:0]  cnt_a;

   int checks   = 0;
   int failures = 0;

   // exp entry: {check_alt, exp_alt, exp_main}; obs entry: {alt, main}
   logic [2:0] exp_q[$];
   logic [1:0] obs_q[$];

   hazard_scoreboard_if #(.REG_W(4)) m_if ();
   hazard_scoreboard_if #(.REG_W(4)) a_if ();

   hazard_scoreboard #(.NUM_REGS(16), .REG_W(4), .LOAD_LAT(2), .STAT_W(16)) u_dut (
      .clk(clk), .rst(rst), .dec(m_if), .mem_ready(mem_ready),
      .stat_clr(stat_clr), .stall_count(cnt_m)
   );

   hazard_scoreboard #(.NUM_REGS(16), .REG_W(4), .LOAD_LAT(3), .STAT_W(3)) u_alt (
      .clk(clk), .rst(rst), .dec(a_if), .mem_ready(mem_ready),
      .stat_clr(stat_clr), .stall_count(cnt_a)
   );

   // clock / reset
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic apply(input dec_t d);
      m_if.dec_valid = d.valid;      a_if.dec_valid = d.valid;
      m_if.dec_rs = d.rs;            a_if.dec_rs = d.rs;
      m_if.dec_rt = d.rt;            a_if.dec_rt = d.rt;
      m_if.dec_rs_used = d.rs_used;  a_if.dec_rs_used = d.rs_used;
      m_if.dec_rt_used = d.rt_used;  a_if.dec_rt_used = d.rt_used;
      m_if.dec_rt_store = d.rt_store; a_if.dec_rt_store = d.rt_store;
      m_if.dec_rd = d.rd;            a_if.dec_rd = d.rd;
      m_if.dec_wr_en = d.wr_en;      a_if.dec_wr_en = d.wr_en;
      m_if.dec_is_load = d.is_load;  a_if.dec_is_load = d.is_load;
      m_if.dec_sets_flags = d.sets_flags; a_if.dec_sets_flags = d.sets_flags;
      m_if.dec_branch = d.branch;    a_if.dec_branch = d.branch;
      m_if.dec_branch_type = d.btype; a_if.dec_branch_type = d.btype;
   endtask

   function automatic dec_t f_idle();
      dec_t d = '0;
      return d;
   endfunction

   function automatic dec_t f_load(input logic [3:0] rd);
      dec_t d = '0;
      d.valid = 1'b1; d.rd = rd; d.wr_en = 1'b1; d.is_load = 1'b1;
      d.rs = 4'(15 - int'(rd)); // unused source, random-looking index
      return d;
   endfunction

   function automatic dec_t f_alu(input logic [3:0] rd, input logic [3:0] rs,
                                  input logic [3:0] rt, input logic rs_used,
                                  input logic rt_used, input logic flags);
      dec_t d = '0;
      d.valid = 1'b1; d.rd = rd; d.wr_en = 1'b1; d.rs = rs; d.rt = rt;
      d.rs_used = rs_used; d.rt_used = rt_used; d.sets_flags = flags;
      return d;
   endfunction

   function automatic dec_t f_store(input logic [3:0] rs, input logic [3:0] rt);
      dec_t d = '0;
      d.valid = 1'b1; d.rs = rs; d.rt = rt; d.rt_used = 1'b1; d.rt_store = 1'b1;
      return d;
   endfunction

   function automatic dec_t f_branch(input logic btype, input logic [3:0] rs);
      dec_t d = '0;
      d.valid = 1'b1; d.branch = 1'b1; d.btype = btype; d.rs = rs;
      d.rs_used = btype;
      return d;
   endfunction

   // Hold current inputs for one cycle: record expectation, sample mid-cycle.
   task automatic step(input logic exp_m, input logic chk_a, input logic exp_a);
      exp_q.push_back({chk_a, exp_a, exp_m});
      @(negedge clk);
      obs_q.push_back({a_if.stall, m_if.stall});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'b1;
      stat_clr = 1'b0;
      apply(f_idle());
      exp_q.delete();
      obs_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [2:0] e;
      logic [1:0] o;
      do_reset();
      checks++;
      if (cnt_m !== 16'd0) begin failures++; $display("FAIL reset_count_main got %0d expected 0", cnt_m); end
      checks++;
      if (cnt_a !== 3'd0) begin failures++; $display("FAIL reset_count_alt got %0d expected 0", cnt_a); end
      step(1'b0, 1'b1, 1'b0);
      apply(f_load(4'd3));
      step(1'b0, 1'b1, 1'b0);
      apply(f_alu(4'd7, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0));
      m_if.dec_valid = 1'b0; a_if.dec_valid = 1'b0;
      step(1'b0, 1'b1, 1'b0);
      apply(f_idle());
      for (int i = 0; exp_q.size() != 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o[0] !== e[0]) begin failures++; $display("FAIL reset stall_main step %0d got %b expected %b", i, o[0], e[0]); end
         if (e[2]) begin
            checks++;
            if (o[1] !== e[1]) begin failures++; $display("FAIL reset stall_alt step %0d got %b expected %b", i, o[1], e[1]); end
         end
      end
   endtask

   task automatic test_load_use();
      logic [2:0] e;
      logic [1:0] o;
      do_reset();
      apply(f_load(4'd3));                              step(1'b0, 1'b0, 1'b0);
      apply(f_alu(4'd7, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0)); step(1'b1, 1'b0, 1'b0);
                                                        step(1'b0, 1'b0, 1'b0);
      apply(f_idle());
      for (int i = 0; exp_q.size() != 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o[0] !== e[0]) begin failures++; $display("FAIL load_use stall_main step %0d got %b expected %b", i, o[0], e[0]); end
      end
      checks++;
      if (cnt_m !== 16'd1) begin failures++; $display("FAIL load_use count got %0d expected 1", cnt_m); end
   endtask

   task automatic test_store();
      logic [2:0] e;
      logic [1:0] o;
      do_reset();
      apply(f_load(4'd5));           step(1'b0, 1'b1, 1'b0);
      apply(f_store(4'd0, 4'd5));    step(1'b0, 1'b1, 1'b1);
                                     step(1'b0, 1'b1, 1'b0);
      apply(f_idle());
      for (int i = 0; exp_q.size() != 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o[0] !== e[0]) begin failures++; $display("FAIL store stall_main step %0d got %b expected %b", i, o[0], e[0]); end
         if (e[2]) begin
            checks++;
            if (o[1] !== e[1]) begin failures++; $display("FAIL store stall_alt step %0d got %b expected %b", i, o[1], e[1]); end
         end
      end
   endtask

   task automatic test_flags();
      logic [2:0] e;
      logic [1:0] o;
      do_reset();
      apply(f_alu(4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1)); step(1'b0, 1'b1, 1'b0);
      apply(f_branch(BR_TYPE_B, 4'd0));                 step(1'b1, 1'b1, 1'b1);
                                                        step(1'b0, 1'b1, 1'b0);
      apply(f_alu(4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1)); step(1'b0, 1'b1, 1'b0);
      apply(f_alu(4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0)); step(1'b0, 1'b1, 1'b0);
      apply(f_branch(BR_TYPE_B, 4'd0));                 step(1'b0, 1'b1, 1'b0);
      apply(f_idle());
      for (int i = 0; exp_q.size() != 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o[0] !== e[0]) begin failures++; $display("FAIL flags stall_main step %0d got %b expected %b", i, o[0], e[0]); end
         if (e[2]) begin
            checks++;
            if (o[1] !== e[1]) begin failures++; $display("FAIL flags stall_alt step %0d got %b expected %b", i, o[1], e[1]); end
         end
      end
      checks++;
      if (cnt_m !== 16'd1) begin failures++; $display("FAIL flags count got %0d expected 1", cnt_m); end
   endtask

   task automatic test_branch_reg();
      logic [2:0] e;
      logic [1:0] o;
      do_reset();
      apply(f_load(4'd4));               step(1'b0, 1'b0, 1'b0);
      apply(f_branch(BR_TYPE_BR, 4'd4)); step(1'b1, 1'b0, 1'b0);
                                         step(1'b1, 1'b0, 1'b0);
                                         step(1'b0, 1'b0, 1'b0);
      apply(f_load(4'd4));               step(1'b0, 1'b0, 1'b0);
      apply(f_branch(BR_TYPE_BR, 4'd4)); step(1'b1, 1'b0, 1'b0);
      mem_ready = 1'b0;
      repeat (3) step(1'b1, 1'b0, 1'b0);
      mem_ready = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      apply(f_idle());
      for (int i = 0; exp_q.size() != 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o[0] !== e[0]) begin failures++; $display("FAIL branch_reg stall_main step %0d got %b expected %b", i, o[0], e[0]); end
      end
      checks++;
      if (cnt_m !== 16'd7) begin failures++; $display("FAIL branch_reg count got %0d expected 7", cnt_m); end
   endtask

   task automatic test_r0_sat();
      logic [2:0] e;
      logic [1:0] o;
      do_reset();
      apply(f_load(4'd0));                              step(1'b0, 1'b1, 1'b0);
      apply(f_alu(4'd7, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0)); step(1'b0, 1'b1, 1'b0);
      apply(f_branch(BR_TYPE_BR, 4'd0));                step(1'b0, 1'b1, 1'b0);
      checks++;
      if (cnt_m !== 16'd0) begin failures++; $display("FAIL r0 count got %0d expected 0", cnt_m); end
      apply(f_load(4'd3));                              step(1'b0, 1'b1, 1'b0);
      apply(f_alu(4'd7, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0));
      mem_ready = 1'b0;
      repeat ($urandom_range(9, 11)) step(1'b1, 1'b1, 1'b1);
      checks++;
      if (cnt_a !== 3'd7) begin failures++; $display("FAIL sat count_alt got %0d expected 7", cnt_a); end
      checks++;
      if (cnt_m < 16'd9) begin failures++; $display("FAIL sat count_main got %0d expected at least 9", cnt_m); end
      stat_clr = 1'b1;
      step(1'b1, 1'b1, 1'b1);
      stat_clr = 1'b0;
      checks++;
      if (cnt_a !== 3'd0) begin failures++; $display("FAIL clr count_alt got %0d expected 0", cnt_a); end
      checks++;
      if (cnt_m !== 16'd0) begin failures++; $display("FAIL clr count_main got %0d expected 0", cnt_m); end
      mem_ready = 1'b1;
      apply(f_idle());
      for (int i = 0; exp_q.size() != 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o[0] !== e[0]) begin failures++; $display("FAIL r0_sat stall_main step %0d got %b expected %b", i, o[0], e[0]); end
         if (e[2]) begin
            checks++;
            if (o[1] !== e[1]) begin failures++; $display("FAIL r0_sat stall_alt step %0d got %b expected %b", i, o[1], e[1]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [2:0] e;
      logic [1:0] o;
      do_reset();
      apply(f_alu(4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1)); step(1'b0, 1'b1, 1'b0);
      apply(f_load(4'd6));                              step(1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      apply(f_idle());
      @(posedge clk);
      #1;
      rst = 1'b0;
      apply(f_alu(4'd8, 4'd6, 4'd6, 1'b1, 1'b1, 1'b0)); step(1'b0, 1'b1, 1'b0);
      apply(f_branch(BR_TYPE_BR, 4'd6));                step(1'b0, 1'b1, 1'b0);
      apply(f_branch(BR_TYPE_B, 4'd0));                 step(1'b0, 1'b1, 1'b0);
      apply(f_idle());
      for (int i = 0; exp_q.size() != 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o[0] !== e[0]) begin failures++; $display("FAIL reset_mid stall_main step %0d got %b expected %b", i, o[0], e[0]); end
         if (e[2]) begin
            checks++;
            if (o[1] !== e[1]) begin failures++; $display("FAIL reset_mid stall_alt step %0d got %b expected %b", i, o[1], e[1]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] e;
      logic [1:0] o;
      do_reset();
      apply(f_load(4'd2));                              step(1'b0, 1'b0, 1'b0);
      apply(f_alu(4'd2, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0)); step(1'b1, 1'b0, 1'b0);
                                                        step(1'b0, 1'b0, 1'b0);
      apply(f_alu(4'd9, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0)); step(1'b0, 1'b0, 1'b0);
      apply(f_load(4'd9));                              step(1'b0, 1'b0, 1'b0);
      apply(f_store(4'd1, 4'd9));                       step(1'b0, 1'b0, 1'b0);
      apply(f_idle());
      for (int i = 0; exp_q.size() != 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o[0] !== e[0]) begin failures++; $display("FAIL back_to_back stall_main step %0d got %b expected %b", i, o[0], e[0]); end
      end
      checks++;
      if (cnt_m !== 16'd1) begin failures++; $display("FAIL back_to_back count got %0d expected 1", cnt_m); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      apply(f_idle());
      test_reset();
      test_load_use();
      test_store();
      test_flags();
      test_branch_reg();
      test_r0_sat();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
